// File: rtl/serial16_pkg.sv
// serial16_pkg
//   Definitions shared by the 16-bit serial link transmitter and receiver:
//   frame state encoding, data width and line levels.
package serial16_pkg;

   localparam int DATA_BITS = 16;

   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b1;

   // PARITY is part of the shared encoding even when a build leaves it unused
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

endpackage

// File: rtl/serial_tx16_bit_timer.sv
// bit_timer
//   Counts clock cycles within one serial bit period and pulses tick on the
//   last cycle of the period, then wraps to zero.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset
//   clear  in   hold the count at zero (no tick while asserted)
//   tick   out  one-cycle pulse when the count reaches CLKS_PER_BIT-1
module bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt;

   assign tick = !clear && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear || tick)
         cnt <= '0;
      else
         cnt <= cnt + 16'd1;
   end

endmodule

// File: rtl/serial_tx16.sv
// serial_tx16
//   Transmit end of the 16-bit serial link. Accepts a word on a valid/ready
//   interface and sends start bit (low), 16 data bits LSB first, optional
//   even-parity bit and stop bit (high) on tx.
//   Build option: define SERIAL_TX16_PARITY_EN to add the parity bit.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   in[15:0]  in   word to send, sampled on accept
//   in_valid  in   producer has a word
//   in_ready  out  idle and able to accept (decoded from state)
//   tx        out  serial line, registered, idles high
//   busy      out  frame in progress, registered
module serial_tx16
   import serial16_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        tx,
   output logic        busy
);

   state_t                 state, state_n;
   logic [DATA_BITS-1:0]   shreg, shreg_n;
   logic [3:0]             idx, idx_n;
   logic                   tx_n, busy_n;
   logic                   tick, clear;
`ifdef SERIAL_TX16_PARITY_EN
   logic                   par, par_n;
`endif

   // Timer held at zero while idle so each frame starts a fresh bit period
   assign clear = (state == IDLE);

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .tick  (tick)
   );

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         shreg <= '0;
         idx   <= '0;
         tx    <= IDLE_LEVEL;
         busy  <= 1'b0;
`ifdef SERIAL_TX16_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         shreg <= shreg_n;
         idx   <= idx_n;
         tx    <= tx_n;
         busy  <= busy_n;
`ifdef SERIAL_TX16_PARITY_EN
         par   <= par_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      idx_n   = idx;
`ifdef SERIAL_TX16_PARITY_EN
      par_n   = par;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_n = START;
               shreg_n = in;
               idx_n   = '0;
`ifdef SERIAL_TX16_PARITY_EN
               par_n   = ^in;
`endif
            end
         end
         START: begin
            if (tick) state_n = DATA;
         end
         DATA: begin
            if (tick) begin
               if (idx == 4'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX16_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  shreg_n = shreg >> 1;
                  idx_n   = idx + 4'd1;
               end
            end
         end
`ifdef SERIAL_TX16_PARITY_EN
         PARITY: begin
            if (tick) state_n = STOP;
         end
`endif
         STOP: begin
            if (tick) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Outputs are registered from the next-state values so tx/busy change
      // on the same edge as the state they describe
      busy_n = (state_n != IDLE);
      case (state_n)
         START:   tx_n = START_LEVEL;
         DATA:    tx_n = shreg_n[0];
`ifdef SERIAL_TX16_PARITY_EN
         PARITY:  tx_n = par_n;
`endif
         STOP:    tx_n = STOP_LEVEL;
         default: tx_n = IDLE_LEVEL;
      endcase
   end

endmodule

// File: tb/tb_serial_tx16.sv
module tb_serial_tx16;

   localparam int CPB = 4;
`ifdef SERIAL_TX16_PARITY_EN
   localparam int NBITS = 19;
`else
   localparam int NBITS = 18;
`endif
   localparam int FRAME = NBITS * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in;
   logic        in_valid;
   logic        in_ready;
   logic        tx;
   logic        busy;

   logic [15:0] exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   serial_tx16 #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_tx"}, 32'(tx), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
   endtask

   // Present w and wait for accept; returns just after the accept edge.
   task automatic send(input logic [15:0] w, input logic hold_valid);
      int n;
      n = 0;
      in = w;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 200) begin
         cyc();
         n++;
      end
      if (n >= 200) chk("ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back(w);
      #1;
      if (!hold_valid) in_valid = 1'b0;
   endtask

   // Checks one full frame starting at its first start-bit cycle, then the
   // single idle cycle that follows. Optionally changes `in` at cycle chg_at.
   task automatic run_frame(input int chg_at, input logic [15:0] chg_val);
      logic [15:0] w;
      int          b;
      int          bcnt;
      logic        e;
      bcnt = 0;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 32'(exp_q.size()), 32'd1);
         return;
      end
      w = exp_q.pop_front();
      for (int c = 0; c < FRAME; c++) begin
         if (c == chg_at) in = chg_val;
         b = c / CPB;
         if (b == 0) e = 1'b0;
         else if (b <= 16) e = w[b-1];
`ifdef SERIAL_TX16_PARITY_EN
         else if (b == 17) e = ^w;
`endif
         else e = 1'b1;
         chk($sformatf("tx_%04h_c%0d", w, c), 32'(tx), 32'(e));
         chk($sformatf("busy_%04h_c%0d", w, c), 32'(busy), 32'd1);
         chk($sformatf("ready_%04h_c%0d", w, c), 32'(in_ready), 32'd0);
         if (busy === 1'b1) bcnt++;
         cyc();
      end
      chk($sformatf("busy_len_%04h", w), 32'(bcnt), 32'(FRAME));
      check_idle($sformatf("post_%04h", w));
   endtask

   initial begin
      reset = 1'b1;
      in = '0;
      in_valid = 1'b0;
      repeat (2) cyc();
      check_idle("in_reset");
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         cyc();
         check_idle("idle");
      end

      // Basic frames, including the parity values of interest
      send(16'hA5C3, 1'b0);
      run_frame(-1, '0);
      cyc();
      send(16'h0001, 1'b0);
      run_frame(-1, '0);

      // Input changes mid-DATA must not affect the frame in flight
      send(16'h0F0F, 1'b0);
      run_frame(CPB * 5, 16'h1234);

      // Back-to-back with in_valid held high: one idle cycle between frames
      send(16'hFFFF, 1'b1);
      in = 16'h0000;
      run_frame(-1, '0);
      @(posedge clk);
      exp_q.push_back(16'h0000);
      #1;
      in_valid = 1'b0;
      run_frame(-1, '0);

      // Reset in the middle of data bit 7 (bit 7 of 5555 is 0)
      send(16'h5555, 1'b0);
      repeat (CPB * 8 + 1) cyc();
      chk("pre_abort_tx", 32'(tx), 32'd0);
      chk("pre_abort_busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_idle("abort");
      exp_q.delete();
      cyc();
      reset = 1'b0;
      repeat (3) begin
         cyc();
         check_idle("post_abort");
      end
      send(16'h8001, 1'b0);
      run_frame(-1, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
